// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one byte-masked write port
// and two independent read ports. Each read port has a one-cycle registered latency.
// The write port optionally bypasses to the read ports on a same-address collision.
// Register 0 can optionally be hardwired to zero.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic               re_a,
  input  logic [AW-1:0]      raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  output logic               rvalid_a,
  input  logic               re_b,
  input  logic [AW-1:0]      raddr_b,
  output logic [WIDTH-1:0]   rdata_b,
  output logic               rvalid_b
);

  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(DEPTH);
  // DEPTH widened by one bit so that an all-ones address still compares correctly
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  // Replace the byte lanes selected by be with the lanes of new_w
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_w,
    input logic [WIDTH-1:0] new_w,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             wr_en_s;
  logic [IW-1:0]    widx_s;
  logic [WIDTH-1:0] wmerged_s;
  logic [WIDTH-1:0] rnext_a_s;
  logic [WIDTH-1:0] rnext_b_s;

  // Write qualification: address in range, not the hardwired zero register
  always_comb begin
    wr_en_s   = 1'b0;
    widx_s    = waddr[IW-1:0];
    wmerged_s = merge_bytes(mem_r[widx_s], wdata, wbe);
    if (we && ({1'b0, waddr} < DEPTH_W) &&
        !(ZERO_REG && (waddr == {AW{1'b0}}))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Port A read word: out-of-range and hardwired-zero reads give 0; the merged
  // write word is forwarded on a collision when bypass is enabled
  always_comb begin
    rnext_a_s = {WIDTH{1'b0}};
    if (!({1'b0, raddr_a} < DEPTH_W)) begin
      rnext_a_s = {WIDTH{1'b0}};
    end else if (ZERO_REG && (raddr_a == {AW{1'b0}})) begin
      rnext_a_s = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (raddr_a == waddr)) begin
      rnext_a_s = wmerged_s;
    end else begin
      rnext_a_s = mem_r[raddr_a[IW-1:0]];
    end
  end

  // Port B read word, same rules as port A
  always_comb begin
    rnext_b_s = {WIDTH{1'b0}};
    if (!({1'b0, raddr_b} < DEPTH_W)) begin
      rnext_b_s = {WIDTH{1'b0}};
    end else if (ZERO_REG && (raddr_b == {AW{1'b0}})) begin
      rnext_b_s = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (raddr_b == waddr)) begin
      rnext_b_s = wmerged_s;
    end else begin
      rnext_b_s = mem_r[raddr_b[IW-1:0]];
    end
  end

  // Register array: cleared on reset, byte-merged update on a qualified write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[widx_s] <= wmerged_s;
    end
  end

  // Port A output register: data captured only on a request, valid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a  <= {WIDTH{1'b0}};
      rvalid_a <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      if (re_a) begin
        rdata_a <= rnext_a_s;
      end
    end
  end

  // Port B output register, same behaviour as port A
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_b  <= {WIDTH{1'b0}};
      rvalid_b <= 1'b0;
    end else begin
      rvalid_b <= re_b;
      if (re_b) begin
        rdata_b <= rnext_b_s;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w. Three instances share the write and
// address inputs: default (bypass on), bypass off, and DEPTH=24.
// Read enables are per instance. Output index p = 2*instance + port (0=A, 1=B).
module tb_regfile_2r1w;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wbe = 4'd0;
  logic [4:0]  raddr_a = 5'd0;
  logic [4:0]  raddr_b = 5'd0;
  logic [2:0]  re_a = 3'd0;
  logic [2:0]  re_b = 3'd0;

  logic [31:0] rd [6];
  logic        rv [6];

  exp_t        exp_q [6][$];
  logic [31:0] last_d [6];
  logic [31:0] cyc = 32'd0;
  logic        rst_q = 1'b0;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  regfile_2r1w u_main (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re_a(re_a[0]), .raddr_a(raddr_a), .rdata_a(rd[0]), .rvalid_a(rv[0]),
    .re_b(re_b[0]), .raddr_b(raddr_b), .rdata_b(rd[1]), .rvalid_b(rv[1])
  );

  regfile_2r1w #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re_a(re_a[1]), .raddr_a(raddr_a), .rdata_a(rd[2]), .rvalid_a(rv[2]),
    .re_b(re_b[1]), .raddr_b(raddr_b), .rdata_b(rd[3]), .rvalid_b(rv[3])
  );

  regfile_2r1w #(.DEPTH(24), .AW(5)) u_d24 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re_a(re_a[2]), .raddr_a(raddr_a), .rdata_a(rd[4]), .rvalid_a(rv[4]),
    .re_b(re_b[2]), .raddr_b(raddr_b), .rdata_b(rd[5]), .rvalid_b(rv[5])
  );

  // Cycle counter and registered copy of reset for the monitor
  always @(posedge clk) begin
    cyc   <= cyc + 32'd1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s port%0d: got %h, required %h (cycle %0d)", name, p, act, req, cyc);
    end
  endtask

  // Monitor: pops the expected word when a response is due, otherwise checks hold
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 6; p++) begin
        logic exp_v;
        exp_t e;
        if (rst_q) begin
          last_d[p] = 32'd0;
          chk("reset rvalid", p, {31'd0, rv[p]}, 32'd0);
          chk("reset rdata", p, rd[p], 32'd0);
        end else begin
          exp_v = (exp_q[p].size() != 0) && (exp_q[p][0].due == cyc);
          chk("rvalid", p, {31'd0, rv[p]}, {31'd0, exp_v});
          if (exp_v) begin
            e = exp_q[p].pop_front();
            last_d[p] = e.data;
            chk("rdata", p, rd[p], e.data);
          end else begin
            chk("rdata hold", p, rd[p], last_d[p]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we   = 1'b0;
    wbe  = 4'd0;
    re_a = 3'd0;
    re_b = 3'd0;
  endtask

  task automatic push(input int p, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 32'd1;
    exp_q[p].push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
  endtask

  // Read A on all instances with per-instance expected words
  task automatic rd_a(input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    re_a = 3'b111; raddr_a = a;
    push(0, e0); push(2, e1); push(4, e2);
  endtask

  task automatic rd_b(input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    re_b = 3'b111; raddr_b = a;
    push(1, e0); push(3, e1); push(5, e2);
  endtask

  initial begin
    for (int p = 0; p < 6; p++) last_d[p] = 32'd0;
    idle();
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // Read after reset returns zero
    rd_a(5'd5, 32'd0, 32'd0, 32'd0);
    step(); idle();

    // Full write then partial byte-lane write
    wr(5'd3, 32'hDEADBEEF, 4'hF); step();
    wr(5'd3, 32'h11223344, 4'b0101); step(); idle();
    rd_a(5'd3, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);
    step(); idle();
    step();

    // Write with no byte lanes enabled changes nothing
    wr(5'd3, 32'h00000000, 4'h0); step(); idle();
    rd_b(5'd3, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);
    step(); idle();

    // Same-cycle collision: bypass on forwards, bypass off returns old word
    wr(5'd7, 32'hCAFEF00D, 4'hF);
    rd_a(5'd7, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D);
    step(); idle();
    rd_b(5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
    step(); idle();
    wr(5'd3, 32'hAABBCCDD, 4'b1010);
    rd_a(5'd3, 32'hAA22CC44, 32'hDE22BE44, 32'hAA22CC44);
    step(); idle();

    // Register 0 is hardwired to zero, including on collision
    wr(5'd0, 32'hFFFFFFFF, 4'hF); step(); idle();
    rd_a(5'd0, 32'd0, 32'd0, 32'd0);
    rd_b(5'd0, 32'd0, 32'd0, 32'd0);
    step(); idle();
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    rd_a(5'd0, 32'd0, 32'd0, 32'd0);
    step(); idle();

    // Out-of-range address on the DEPTH=24 instance
    wr(5'd30, 32'h12345678, 4'hF); step(); idle();
    rd_a(5'd30, 32'h12345678, 32'h12345678, 32'd0);
    rd_b(5'd23, 32'd0, 32'd0, 32'd0);
    step(); idle();

    // Fill 1..31 with their own address
    for (int a = 1; a < 32; a++) begin
      wr(a[4:0], 32'(a), 4'hF);
      step();
    end
    idle();
    rd_a(5'd9, 32'd9, 32'd9, 32'd9);
    rd_b(5'd9, 32'd9, 32'd9, 32'd9);
    step(); idle();
    rd_a(5'd31, 32'd31, 32'd31, 32'd0);
    rd_b(5'd23, 32'd23, 32'd23, 32'd23);
    step(); idle();

    // Reset with a concurrent read: no valid, contents cleared
    rst = 1'b1;
    re_a = 3'b111; raddr_a = 5'd9;
    wr(5'd9, 32'h55555555, 4'hF);
    step();
    rst = 1'b0; idle();
    rd_a(5'd9, 32'd0, 32'd0, 32'd0);
    rd_b(5'd31, 32'd0, 32'd0, 32'd0);
    step(); idle();

    // First cycles after reset accept writes and reads normally
    wr(5'd4, 32'h000000A5, 4'hF);
    rd_a(5'd4, 32'h000000A5, 32'd0, 32'h000000A5);
    step(); idle();
    rd_b(5'd4, 32'h000000A5, 32'h000000A5, 32'h000000A5);
    step(); idle();

    step(); step(); step();
    for (int p = 0; p < 6; p++) begin
      chk("pending responses", p, 32'(exp_q[p].size()), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 32: number of registers, minimum 2.
REQ-003 Parameter AW, default $clog2(DEPTH): address width; SHALL be at least $clog2(DEPTH).
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-005 Parameter BYPASS, default 1: when 1, a read returns write data from the same cycle.
REQ-006 clk  in  1  sole clock, all state on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 we  in  1  write enable.
REQ-009 waddr  in  AW  write address.
REQ-010 wdata  in  WIDTH  write data.
REQ-011 wbe  in  WIDTH/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-012 re_a  in  1  port A read request.
REQ-013 raddr_a  in  AW  port A read address.
REQ-014 rdata_a  out  WIDTH  port A registered read data.
REQ-015 rvalid_a  out  1  port A read data valid.
REQ-016 re_b, raddr_b, rdata_b, rvalid_b: port B, identical to REQ-012..015.

Function
REQ-017 Write: at posedge with rst=0, we=1 and waddr<DEPTH, each byte lane i with wbe[i]=1 SHALL take wdata lane i; lanes with wbe[i]=0 hold.
REQ-018 we=1 with wbe all-zero SHALL leave the register unchanged.
REQ-019 A write with waddr>=DEPTH SHALL be ignored; no other register changes.
REQ-020 With ZERO_REG=1, writes to address 0 SHALL be ignored, and register 0 SHALL always read as 0.
REQ-021 Read latency SHALL be exactly 1 cycle. A request (re_x=1) at edge N presents data on rdata_x after edge N, and rvalid_x=1 for that cycle only.
REQ-022 When re_x=0, rdata_x SHALL hold its last value and rvalid_x SHALL be 0 after the edge.
REQ-023 A read with raddr_x>=DEPTH SHALL return 0 with rvalid_x=1.
REQ-024 Same-address collision, BYPASS=1: a read sampled in the same cycle as a write to the same address SHALL return the merged post-write word (new bytes where wbe=1, old bytes elsewhere).
REQ-025 Same-address collision, BYPASS=0: the read SHALL return the pre-write word.
REQ-026 A collision on address 0 with ZERO_REG=1 SHALL return 0 regardless of BYPASS.
REQ-027 Ports A and B SHALL be fully independent. Both may read the same address in one cycle, and both SHALL see identical data.
REQ-028 There SHALL be no combinational path from any input to rdata_x or rvalid_x.

Reset
REQ-029 At posedge with rst=1, all DEPTH registers SHALL clear to 0, and rdata_a, rdata_b, rvalid_a, rvalid_b SHALL clear to 0.
REQ-030 While rst=1, writes and read requests SHALL be ignored; rst has priority over we and re_x.
REQ-031 A read issued in the cycle rst asserts SHALL NOT produce rvalid. The first cycle after rst deasserts SHALL accept writes and reads normally.

Verification
REQ-032 Reset, then re_a=1 with raddr_a=5 -> next cycle rdata_a=0 and rvalid_a=1.
REQ-033 Write 0xDEADBEEF to addr 3 (wbe=4'hF), then write 0x11223344 to addr 3 with wbe=4'b0101, then read A@3 -> rdata_a=0xDE22BE44.
REQ-034 BYPASS=1: write 0xCAFEF00D to addr 7 and read A@7 in the same cycle -> next cycle rdata_a=0xCAFEF00D. BYPASS=0, same stimulus with addr 7 previously 0 -> rdata_a=0.
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to addr 0, then read A@0 and B@0 -> both rdata=0 and both rvalid=1.
REQ-036 DEPTH=24, AW=5: write 0x12345678 to addr 30, then read A@30 and B@23 -> rdata_a=0 and rdata_b unchanged from prior contents (0 after reset).
REQ-037 Fill addr 1..31 with the value equal to their address, assert rst for 1 cycle together with re_a=1 at addr 9, then read addr 9 -> rvalid_a=0 during reset, and the subsequent read returns 0.
